// File: rtl/fb_fill_pkg.sv
// Shared constants and types for the framebuffer fill engine.
// Register map, CTRL bit positions, reset stride and FSM state encoding.
package fb_fill_pkg;

    localparam int FB_AW   = 19;
    localparam int FB_WMAX = 12;
    localparam int FB_HMAX = 10;

    localparam logic [2:0] REG_BASE   = 3'd0;
    localparam logic [2:0] REG_STRIDE = 3'd1;
    localparam logic [2:0] REG_WIDTH  = 3'd2;
    localparam logic [2:0] REG_HEIGHT = 3'd3;
    localparam logic [2:0] REG_COLOUR = 3'd4;
    localparam logic [2:0] REG_CTRL   = 3'd5;

    localparam int CTRL_START = 0;
    localparam int CTRL_ABORT = 1;

    localparam int STRIDE_RST = 256;

    typedef enum logic [1:0] {
        IDLE,
        LINE_SETUP,
        WRITE,
        DONE
    } fill_state_e;

endpackage

// File: rtl/fb_fill_if.sv
// Bus bundle around the fill engine: CPU port, config port and the
// framebuffer write port it arbitrates.
interface fb_fill_if #(
    parameter int AW = 19
);
    logic          cpu_en;
    logic [7:0]    cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [63:0]   cpu_wrdata;
    logic [63:0]   cpu_rddata;

    logic          cfg_en;
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [31:0]   cfg_wrdata;
    logic [31:0]   cfg_rddata;

    logic          fb_en;
    logic [7:0]    fb_we;
    logic [AW-4:0] fb_addr;
    logic [63:0]   fb_wrdata;
    logic [63:0]   fb_rddata;

    logic          irq;

    modport slave (
        input  cpu_en, cpu_we, cpu_addr, cpu_wrdata,
        output cpu_rddata,
        input  cfg_en, cfg_we, cfg_addr, cfg_wrdata,
        output cfg_rddata,
        output fb_en, fb_we, fb_addr, fb_wrdata,
        input  fb_rddata,
        output irq
    );

    modport master (
        output cpu_en, cpu_we, cpu_addr, cpu_wrdata,
        input  cpu_rddata,
        output cfg_en, cfg_we, cfg_addr, cfg_wrdata,
        input  cfg_rddata,
        input  fb_en, fb_we, fb_addr, fb_wrdata,
        output fb_rddata,
        input  irq
    );

endinterface

// File: rtl/fb_fill_mask.sv
// Word range and edge byte masks for one fill line starting at line_base.
// The end address wraps modulo 2^AW.
module fb_fill_mask #(
    parameter int AW   = 19,
    parameter int WMAX = 12
) (
    input  logic [AW-1:0]   line_base,
    input  logic [WMAX-1:0] width,
    output logic [AW-4:0]   first_word,
    output logic [AW-4:0]   last_word,
    output logic [7:0]      lmask,
    output logic [7:0]      rmask
);

    logic [AW-1:0] line_end;

    assign line_end   = line_base + AW'(width) - AW'(1);
    assign first_word = line_base[AW-1:3];
    assign last_word  = line_end[AW-1:3];
    assign lmask      = 8'hFF << line_base[2:0];
    assign rmask      = 8'hFF >> (3'd7 - line_end[2:0]);

endmodule

// File: rtl/fb_fill_engine.sv
// Rectangle-fill engine sharing the framebuffer write port with the CPU.
// CPU has fixed priority; the engine simply stalls while cpu_en is high.
module fb_fill_engine
    import fb_fill_pkg::*;
#(
    parameter int AW   = FB_AW,
    parameter int WMAX = FB_WMAX,
    parameter int HMAX = FB_HMAX
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    fb_fill_if.slave  bus
);

    fill_state_e   state;

    logic [AW-1:0]   base;
    logic [WMAX-1:0] stride;
    logic [WMAX-1:0] width;
    logic [HMAX-1:0] height;
    logic [7:0]      colour;
    logic            done;
    logic            aborted;
    logic [31:0]     rd_q;

    logic [AW-1:0]   line_base;
    logic [HMAX-1:0] lines_left;
    logic [AW-4:0]   waddr;
    logic [AW-4:0]   first_word;
    logic [AW-4:0]   last_word;
    logic [7:0]      lmask;
    logic [7:0]      rmask;

    logic [AW-4:0]   m_first;
    logic [AW-4:0]   m_last;
    logic [7:0]      m_lmask;
    logic [7:0]      m_rmask;

    logic            busy;
    logic            cfg_wr;
    logic            ctrl_wr;
    logic            start;
    logic            abort;
    logic            grant;
    logic            last_hit;
    logic [7:0]      eng_we;
    logic [31:0]     rd_mux;
    logic            unused_ok;

    fb_fill_mask #(
        .AW   (AW),
        .WMAX (WMAX)
    ) u_mask (
        .line_base  (line_base),
        .width      (width),
        .first_word (m_first),
        .last_word  (m_last),
        .lmask      (m_lmask),
        .rmask      (m_rmask)
    );

    assign busy    = (state != IDLE);
    assign cfg_wr  = bus.cfg_en && bus.cfg_we;
    assign ctrl_wr = cfg_wr && (bus.cfg_addr == REG_CTRL);
    // abort beats start when both bits are set in one write
    assign abort   = ctrl_wr && bus.cfg_wrdata[CTRL_ABORT];
    assign start   = ctrl_wr && bus.cfg_wrdata[CTRL_START] && !abort;

    assign grant    = (state == WRITE) && !bus.cpu_en;
    assign last_hit = (waddr == last_word);
    assign eng_we   = ((waddr == first_word) ? lmask : 8'hFF)
                    & (last_hit ? rmask : 8'hFF);

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            bus.cfg_addr == REG_BASE:   rd_mux = 32'(base);
            bus.cfg_addr == REG_STRIDE: rd_mux = 32'(stride);
            bus.cfg_addr == REG_WIDTH:  rd_mux = 32'(width);
            bus.cfg_addr == REG_HEIGHT: rd_mux = 32'(height);
            bus.cfg_addr == REG_COLOUR: rd_mux = 32'(colour);
            bus.cfg_addr == REG_CTRL:   rd_mux = {29'd0, aborted, done, busy};
            default:                    rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            base       <= '0;
            stride     <= WMAX'(STRIDE_RST);
            width      <= '0;
            height     <= '0;
            colour     <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            rd_q       <= '0;
            line_base  <= '0;
            lines_left <= '0;
            waddr      <= '0;
            first_word <= '0;
            last_word  <= '0;
            lmask      <= '0;
            rmask      <= '0;
        end else begin
            if (bus.cfg_en && !bus.cfg_we) begin
                rd_q <= rd_mux;
            end
            if (cfg_wr && !busy) begin
                unique case (1'b1)
                    bus.cfg_addr == REG_BASE:   base   <= bus.cfg_wrdata[AW-1:0];
                    bus.cfg_addr == REG_STRIDE: stride <= bus.cfg_wrdata[WMAX-1:0];
                    bus.cfg_addr == REG_WIDTH:  width  <= bus.cfg_wrdata[WMAX-1:0];
                    bus.cfg_addr == REG_HEIGHT: height <= bus.cfg_wrdata[HMAX-1:0];
                    bus.cfg_addr == REG_COLOUR: colour <= bus.cfg_wrdata[7:0];
                    default: ;
                endcase
            end
            if (abort && busy) begin
                state   <= IDLE;
                aborted <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start) begin
                            done    <= 1'b0;
                            aborted <= 1'b0;
                            if (width == '0 || height == '0) begin
                                state <= DONE;
                            end else begin
                                line_base  <= base;
                                lines_left <= height;
                                state      <= LINE_SETUP;
                            end
                        end
                    end
                    LINE_SETUP: begin
                        first_word <= m_first;
                        last_word  <= m_last;
                        lmask      <= m_lmask;
                        rmask      <= m_rmask;
                        waddr      <= m_first;
                        state      <= WRITE;
                    end
                    WRITE: begin
                        if (grant) begin
                            if (last_hit) begin
                                lines_left <= lines_left - HMAX'(1);
                                if (lines_left != HMAX'(1)) begin
                                    line_base <= line_base + AW'(stride);
                                    state     <= LINE_SETUP;
                                end else begin
                                    state <= DONE;
                                end
                            end else begin
                                waddr <= waddr + 1'b1;
                            end
                        end
                    end
                    DONE: begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.fb_en     = bus.cpu_en | grant;
    assign bus.fb_we     = bus.cpu_en ? bus.cpu_we :
                           grant      ? eng_we     : 8'h00;
    assign bus.fb_addr   = bus.cpu_en ? bus.cpu_addr[AW-1:3] :
                           grant      ? waddr                : '0;
    assign bus.fb_wrdata = bus.cpu_en ? bus.cpu_wrdata :
                           grant      ? {8{colour}}    : 64'd0;

    assign bus.cpu_rddata = bus.fb_rddata;
    assign bus.cfg_rddata = rd_q;
    assign bus.irq        = done;

    assign unused_ok = ^{bus.cpu_addr[2:0], bus.cfg_wrdata[31:AW]};

endmodule

// File: tb/tb_fb_fill_engine.sv
// Bench for fb_fill_engine: vector table, corner sequences and random
// fills checked against a byte-level model of the fill rectangle.
module tb_fb_fill_engine;
    import fb_fill_pkg::*;

    localparam int AW = 19;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fb_fill_if #(.AW(AW)) bus ();

    fb_fill_engine dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  we;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        int unsigned base;
        int unsigned stride;
        int unsigned width;
        int unsigned height;
        logic [7:0]  col;
        int          n;
        logic [15:0] fa;
        logic [7:0]  fw;
        logic [15:0] la;
        logic [7:0]  lw;
        int          cost;
    } vec_t;

    wr_t cap_q[$];
    wr_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // engine writes are captured; CPU cycles must pass through untouched
    always @(negedge clk) begin
        if (rst_n && bus.fb_en === 1'b1 && bus.cpu_en === 1'b0)
            cap_q.push_back('{addr: bus.fb_addr, we: bus.fb_we,
                              data: bus.fb_wrdata});
        if (rst_n && bus.cpu_en === 1'b1) begin
            chk("cpu_mirror_ctl", 64'({bus.fb_en, bus.fb_we, bus.fb_addr}),
                64'({1'b1, bus.cpu_we, bus.cpu_addr[18:3]}));
            chk("cpu_mirror_data", bus.fb_wrdata, bus.cpu_wrdata);
        end
    end

    // expected writes: walk every byte of the rectangle, group per word
    function automatic int model(input int unsigned base, input int unsigned stride,
                                 input int unsigned width, input int unsigned height,
                                 input logic [7:0] col);
        int cost;
        int nw;
        int unsigned lb;
        int unsigned a;
        logic [15:0] w;
        wr_t cur;
        bit have;
        cost = 2;
        exp_q.delete();
        cur = '{addr: 16'h0, we: 8'h0, data: 64'h0};
        for (int l = 0; l < int'(height); l++) begin
            if (width == 0) break;
            lb = (base + l * stride) % (1 << AW);
            nw = 0;
            have = 0;
            for (int b = 0; b < int'(width); b++) begin
                a = (lb + b) % (1 << AW);
                w = a[18:3];
                if (have && cur.addr != w) begin
                    exp_q.push_back(cur);
                    nw++;
                    have = 0;
                end
                if (!have) begin
                    cur.addr = w;
                    cur.we = 8'h00;
                    cur.data = {8{col}};
                    have = 1;
                end
                cur.we[a % 8] = 1'b1;
            end
            if (have) begin
                exp_q.push_back(cur);
                nw++;
            end
            cost += nw + 1;
        end
        return cost;
    endfunction

    task automatic cmp_writes(input string tag);
        chk({tag, "_count"}, 64'(cap_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            chk({tag, "_addr_we"}, 64'({cap_q[i].addr, cap_q[i].we}),
                64'({exp_q[i].addr, exp_q[i].we}));
            chk({tag, "_data"}, cap_q[i].data, exp_q[i].data);
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        bus.cfg_en = 1'b1;
        bus.cfg_we = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_wrdata = d;
        @(posedge clk); #1;
        bus.cfg_en = 1'b0;
        bus.cfg_we = 1'b0;
    endtask

    task automatic cfg_read(input logic [2:0] a, output logic [31:0] d);
        bus.cfg_en = 1'b1;
        bus.cfg_we = 1'b0;
        bus.cfg_addr = a;
        @(posedge clk); #1;
        bus.cfg_en = 1'b0;
        d = bus.cfg_rddata;
    endtask

    task automatic setup(input int unsigned b, input int unsigned s,
                         input int unsigned w, input int unsigned h,
                         input logic [7:0] c);
        cfg_write(REG_BASE, b);
        cfg_write(REG_STRIDE, s);
        cfg_write(REG_WIDTH, w);
        cfg_write(REG_HEIGHT, h);
        cfg_write(REG_COLOUR, 32'(c));
    endtask

    task automatic start_fill(output int unsigned c0);
        cap_q.delete();
        cfg_write(REG_CTRL, 32'h1);
        c0 = cyc;
    endtask

    task automatic cpu_drive(input bit en);
        bus.cpu_en = en;
        bus.cpu_we = 8'($urandom);
        bus.cpu_addr = AW'($urandom);
        bus.cpu_wrdata = {$urandom, $urandom};
    endtask

    task automatic wait_done(input int unsigned c0, input bit noise,
                             output int cost);
        int n;
        n = 0;
        while (bus.irq !== 1'b1 && n < 4000) begin
            if (noise) cpu_drive($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            n++;
        end
        if (noise) bus.cpu_en = 1'b0;
        chk("done_seen", 64'(bus.irq), 64'h1);
        cost = int'(cyc - c0) + 1;
    endtask

    vec_t tv[7];
    logic [31:0] rd;
    int cost;
    int mcost;
    int unsigned c0;
    int hold_n;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.cpu_en = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wrdata = 0;
        bus.cfg_en = 0; bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_wrdata = 0;
        bus.fb_rddata = 0;

        tv[0] = '{32'h100, 256, 16, 2, 8'h5A, 4, 16'h20, 8'hFF, 16'h41, 8'hFF, 8};
        tv[1] = '{32'h103, 256, 3, 1, 8'hA5, 1, 16'h20, 8'h38, 16'h20, 8'h38, 4};
        tv[2] = '{32'h105, 256, 12, 1, 8'h3C, 3, 16'h20, 8'hE0, 16'h22, 8'h01, 6};
        tv[3] = '{32'h7FFFC, 256, 8, 1, 8'h81, 2, 16'hFFFF, 8'hF0, 16'h0000, 8'h0F, 5};
        tv[4] = '{32'h40, 0, 8, 3, 8'h11, 3, 16'h8, 8'hFF, 16'h8, 8'hFF, 8};
        tv[5] = '{32'h7, 256, 1, 1, 8'hE7, 1, 16'h0, 8'h80, 16'h0, 8'h80, 4};
        tv[6] = '{32'h100, 256, 16, 0, 8'h5A, 0, 16'h0, 8'h0, 16'h0, 8'h0, 2};

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_irq", 64'(bus.irq), 64'h0);
        chk("rst_cfg_rddata", 64'(bus.cfg_rddata), 64'h0);
        chk("rst_fb_en_idle", 64'(bus.fb_en), 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        cfg_read(REG_STRIDE, rd); chk("rst_stride", 64'(rd), 64'd256);
        cfg_read(REG_BASE, rd);   chk("rst_base", 64'(rd), 64'h0);
        cfg_read(REG_STRIDE, rd);
        cfg_read(3'd6, rd);       chk("reg6_zero", 64'(rd), 64'h0);
        cfg_read(REG_STRIDE, rd);
        cfg_read(3'd7, rd);       chk("reg7_zero", 64'(rd), 64'h0);
        cfg_read(REG_WIDTH, rd);  chk("rst_width", 64'(rd), 64'h0);
        cfg_read(REG_HEIGHT, rd); chk("rst_height", 64'(rd), 64'h0);
        cfg_read(REG_COLOUR, rd); chk("rst_colour", 64'(rd), 64'h0);
        cfg_read(REG_CTRL, rd);   chk("rst_status", 64'(rd), 64'h0);

        bus.fb_rddata = 64'hDEAD_BEEF_0123_4567;
        #1;
        chk("rddata_pass", bus.cpu_rddata, 64'hDEAD_BEEF_0123_4567);

        // register field widths
        setup(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hFF);
        cfg_read(REG_BASE, rd);   chk("base_mask", 64'(rd), 64'h7FFFF);
        cfg_read(REG_STRIDE, rd); chk("stride_mask", 64'(rd), 64'hFFF);
        cfg_read(REG_HEIGHT, rd); chk("height_mask", 64'(rd), 64'h3FF);

        // vector table
        for (int i = 0; i < 7; i++) begin
            setup(tv[i].base, tv[i].stride, tv[i].width, tv[i].height, tv[i].col);
            start_fill(c0);
            wait_done(c0, 0, cost);
            chk("tv_count", 64'(cap_q.size()), 64'(tv[i].n));
            if (tv[i].n > 0 && cap_q.size() > 0) begin
                chk("tv_first", 64'({cap_q[0].addr, cap_q[0].we}),
                    64'({tv[i].fa, tv[i].fw}));
                chk("tv_last", 64'({cap_q[$].addr, cap_q[$].we}),
                    64'({tv[i].la, tv[i].lw}));
                chk("tv_colour", cap_q[0].data, {8{tv[i].col}});
            end
            chk("tv_cost", 64'(cost), 64'(tv[i].cost));
            chk("tv_irq", 64'(bus.irq), 64'h1);
            cfg_read(REG_CTRL, rd);
            chk("tv_status", 64'(rd), 64'h2);
            mcost = model(tv[i].base, tv[i].stride, tv[i].width,
                          tv[i].height, tv[i].col);
            chk("tv_model_cost", 64'(cost), 64'(mcost));
            cmp_writes("tv");
        end

        // CPU stalls the engine for 3 cycles on the second word
        setup(32'h200, 256, 32, 1, 8'hC3);
        start_fill(c0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.cpu_en = 1'b1;
        bus.cpu_we = 8'h0F;
        bus.cpu_addr = 19'h12345;
        bus.cpu_wrdata = 64'h0102_0304_0506_0708;
        repeat (3) begin
            @(posedge clk); #1;
        end
        bus.cpu_en = 1'b0;
        wait_done(c0, 0, cost);
        chk("stall_cost", 64'(cost), 64'd10);
        void'(model(32'h200, 256, 32, 1, 8'hC3));
        cmp_writes("stall");

        // start and BASE write while busy are ignored
        setup(32'h1000, 256, 64, 2, 8'h33);
        start_fill(c0);
        cfg_write(REG_BASE, 32'h2000);
        cfg_write(REG_CTRL, 32'h1);
        wait_done(c0, 0, cost);
        chk("busy_start_cost", 64'(cost), 64'd20);
        void'(model(32'h1000, 256, 64, 2, 8'h33));
        cmp_writes("busy_start");
        cfg_read(REG_BASE, rd);
        chk("busy_base_kept", 64'(rd), 64'h1000);

        // abort after three granted words
        setup(32'h0, 256, 256, 1, 8'h77);
        start_fill(c0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        cfg_write(REG_CTRL, 32'h2);
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("abort_count", 64'(cap_q.size()), 64'd3);
        void'(model(32'h0, 256, 256, 1, 8'h77));
        while (exp_q.size() > 3) void'(exp_q.pop_back());
        cmp_writes("abort");
        chk("abort_irq", 64'(bus.irq), 64'h0);
        cfg_read(REG_CTRL, rd);
        chk("abort_status", 64'(rd), 64'h4);

        // abort alone, then start+abort, in IDLE
        cap_q.delete();
        cfg_write(REG_CTRL, 32'h2);
        cfg_read(REG_CTRL, rd);
        chk("idle_abort_status", 64'(rd), 64'h4);
        cfg_write(REG_CTRL, 32'h3);
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("start_abort_writes", 64'(cap_q.size()), 64'h0);
        cfg_read(REG_CTRL, rd);
        chk("start_abort_status", 64'(rd), 64'h4);

        // reset in the middle of a fill
        setup(32'h0, 256, 256, 2, 8'h99);
        start_fill(c0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        cfg_read(REG_CTRL, rd);
        rst_n = 1'b0;
        hold_n = cap_q.size();
        #1;
        chk("rstmid_fb_en", 64'(bus.fb_en), 64'h0);
        @(negedge clk);
        chk("rstmid_fb_en_neg", 64'(bus.fb_en), 64'h0);
        chk("rstmid_irq", 64'(bus.irq), 64'h0);
        bus.cpu_en = 1'b1;
        bus.cpu_we = 8'hAA;
        bus.cpu_addr = 19'h0ABC8;
        bus.cpu_wrdata = 64'h1111_2222_3333_4444;
        #1;
        chk("rstmid_cpu_mirror", 64'({bus.fb_en, bus.fb_we, bus.fb_addr}),
            64'({1'b1, 8'hAA, 16'h1579}));
        chk("rstmid_cpu_data", bus.fb_wrdata, 64'h1111_2222_3333_4444);
        bus.cpu_en = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_cfg_rddata", 64'(bus.cfg_rddata), 64'h0);
        rst_n = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("rstmid_no_writes", 64'(cap_q.size()), 64'(hold_n));
        cfg_read(REG_BASE, rd);   chk("rstmid_base", 64'(rd), 64'h0);
        cfg_read(REG_STRIDE, rd); chk("rstmid_stride", 64'(rd), 64'd256);
        cfg_read(REG_WIDTH, rd);  chk("rstmid_width", 64'(rd), 64'h0);
        cfg_read(REG_CTRL, rd);   chk("rstmid_status", 64'(rd), 64'h0);

        // random fills, half with CPU traffic
        for (int it = 0; it < 30; it++) begin
            int unsigned rb;
            int unsigned rs;
            int unsigned rw;
            int unsigned rh;
            logic [7:0] rc;
            bit noise;
            rb = $urandom & 32'h7FFFF;
            rs = $urandom_range(0, 4095);
            rw = $urandom_range(0, 80);
            rh = $urandom_range(0, 4);
            rc = 8'($urandom);
            noise = 1'($urandom_range(0, 1));
            setup(rb, rs, rw, rh, rc);
            start_fill(c0);
            wait_done(c0, noise, cost);
            mcost = model(rb, rs, rw, rh, rc);
            cmp_writes("rand");
            if (!noise) chk("rand_cost", 64'(cost), 64'(mcost));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fb_fill_engine.md
Name: fb_fill_engine

Overview:
- Rectangle-fill accelerator and write-port arbiter for the graphics framebuffer (64-bit words, byte-addressed, 19-bit space).
- Sits between the CPU HID bus and the framebuffer write port. Merges CPU accesses with engine-generated palette-index fill writes.
- CPU has fixed priority. The engine stalls whenever the CPU owns the port.

Parameters:
- AW, 19, framebuffer byte-address width
- WMAX, 12, width of the WIDTH and STRIDE registers in bytes
- HMAX, 10, width of the HEIGHT register in lines

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  reset, asynchronous, active-low
- cpu_en  in  1  CPU framebuffer access valid
- cpu_we  in  8  CPU byte write enables
- cpu_addr  in  AW  CPU byte address
- cpu_wrdata  in  64  CPU write data
- cpu_rddata  out  64  read data, passthrough of fb_rddata
- cfg_en  in  1  register access strobe
- cfg_we  in  1  register write
- cfg_addr  in  3  register index
- cfg_wrdata  in  32  register write data
- cfg_rddata  out  32  register read data, registered
- fb_en  out  1  framebuffer port enable
- fb_we  out  8  byte write enables
- fb_addr  out  AW-3  word address
- fb_wrdata  out  64  write data
- fb_rddata  in  64  framebuffer read data
- irq  out  1  level interrupt, equals done status bit

Behaviour:
- Clock and reset: one clock (clk_i). Reset rst_ni is asynchronous and active-low.
- Reset values: state IDLE; all registers 0 except STRIDE=256; cfg_rddata=0; irq=0. Engine-side requests are 0, so fb_* mirrors cpu_* (fb_en=cpu_en).
- Registers (index: meaning):
  - 0 BASE[AW-1:0]
  - 1 STRIDE[WMAX-1:0]
  - 2 WIDTH[WMAX-1:0]
  - 3 HEIGHT[HMAX-1:0]
  - 4 COLOUR[7:0]
  - 5 CTRL: write bit0=start, bit1=abort; read {aborted,done,busy} in bits 2:0
  - 6-7: read 0
- cfg_rddata updates on the cycle after a read strobe.
- Writes to registers 0-4 while busy are ignored. The geometry is copied to working registers at start.
- FSM states: IDLE, LINE_SETUP, WRITE, DONE.
  - IDLE + start: clear done and aborted. If WIDTH=0 or HEIGHT=0, go to DONE. Otherwise set line_base=BASE, lines_left=HEIGHT, go to LINE_SETUP.
  - LINE_SETUP (1 cycle): compute s=line_base, e=s+WIDTH-1 (mod 2^AW), first word s[AW-1:3], last word e[AW-1:3].
    - Masks: lmask=8'hFF<<s[2:0], rmask=8'hFF>>(7-e[2:0]).
    - Go to WRITE with waddr=first word.
  - WRITE: engine request asserted every cycle. It is granted only when cpu_en=0.
    - On grant: fb_we = lmask on the first word, rmask on the last word, lmask&rmask on a single-word line, 8'hFF otherwise. fb_addr=waddr, fb_wrdata={8{COLOUR}}.
    - On a stall: hold waddr and do not advance.
    - After the granted last word: decrement lines_left. If it is nonzero, line_base+=STRIDE and go to LINE_SETUP. Otherwise go to DONE.
  - DONE (1 cycle): set done and irq, go to IDLE.
- busy=1 in every state except IDLE.
- Latency:
  - cfg start write in cycle N: busy=1 from N+1; first fb write no earlier than N+2.
  - Uncontended cost: sum over lines of (words+1), plus 2 cycles.
- Arbitration: combinational mux. When cpu_en=1, fb_en/fb_we/fb_addr/fb_wrdata = CPU values (byte address [AW-1:3]). Otherwise they carry the engine's values when granted, else zero with fb_en=0.
- Boundary rules:
  - Start while busy: ignored.
  - Abort while busy: next state IDLE, set aborted, no further writes; a write granted in the same cycle still occurs. Abort in IDLE: no effect.
  - Start and abort in the same write: abort wins, start is ignored.
  - Address arithmetic wraps modulo 2^AW. STRIDE=0 refills the same line HEIGHT times.
  - Reset mid-fill: immediate IDLE, with no further writes once rst_ni is low.

Decomposition:
- Package fb_fill_pkg holds the state enum, the register index constants (REG_BASE…REG_CTRL), CTRL bit positions and the reset STRIDE.
- One natural sub-module: fb_fill_mask (combinational lmask/rmask/word-range generator from s, WIDTH).

Test Plan:
- BASE=0x100, STRIDE=256, WIDTH=16, HEIGHT=2, COLOUR=0x5A -> writes to words 0x20,0x21,0x40,0x41, all fb_we=FF, data 0x5A5A…5A. done/irq after 8 cycles; busy falls.
- BASE=0x103, WIDTH=3, HEIGHT=1 -> one write, word 0x20, fb_we=0x38.
- BASE=0x105, WIDTH=12, HEIGHT=1 -> word 0x20 we=0xE0, then word 0x21 we=0xFF, then word 0x22 we=0x01.
- Fill of 4 words with cpu_en held for 3 cycles during the 2nd word -> CPU writes appear unaltered on fb_*; the engine word is reissued after the stall; exactly 4 engine writes total.
- HEIGHT=0 start -> no fb writes, done=1 two cycles later. Start while busy -> no restart. Abort mid-line -> no further writes, status=3'b100.
- Assert rst_ni low mid-fill -> fb_en follows cpu_en immediately, all registers restore reset values, irq=0.
